word_sdram_port: RTL and testbench

Memory-side counterpart of the serial word bridge. It accepts 16-bit words assembled by the serial receiver and writes them to SDRAM at sequential addresses. It also services next-word read requests from the serial transmitter, fetching sequential SDRAM words and returning them with an explicit valid pulse. It sits between the serial control block and the SDRAM controller's single-port request/acknowledge interface.

---
 rtl/word_sdram_port_pkg.sv | 21 ++
 rtl/word_fifo.sv | 62 ++++++
 rtl/word_sdram_port.sv | 182 ++++++++++++++++++
 tb/tb_word_sdram_port.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_sdram_port_pkg.sv
// Shared types and constants for the SDRAM word port: FSM states, pointer sizing, error bit positions.
package word_sdram_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int DEF_FRAME_WORDS = 784;
  localparam int PTR_W           = $clog2(DEF_FRAME_WORDS);

  localparam int ERR_WOVF = 0;
  localparam int ERR_ROVR = 1;

  // Pointer width for an arbitrary frame size; never narrower than one bit.
  function automatic int ptr_width(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with count-based full/empty; a push while full is dropped.
module word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_idx_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (push_ok) wr_idx_d = wr_idx_q + AW'(1);
    if (pop_ok)  rd_idx_d = rd_idx_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx_q] <= push_data;
  end

endmodule

// File: rtl/word_sdram_port.sv
// Buffers received words into sequential SDRAM writes and serves next-word reads,
// arbitrating both onto a single request/acknowledge SDRAM port.
module word_sdram_port
  import word_sdram_port_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_word_val,
  input  logic [15:0]       wr_word,
  input  logic              rd_req,
  output logic [15:0]       rd_word,
  output logic              rd_word_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] wr_cnt,
  output logic [ADDR_W-1:0] rd_cnt,
  output logic              frame_done,
  output logic [1:0]        err
);

  localparam int PW = ptr_width(FRAME_WORDS);
  localparam logic [PW-1:0]     PTR_LAST = PW'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       rd_word_q, rd_word_d;
  logic              rd_word_val_q, rd_word_val_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        err_q, err_d;

  logic              fifo_pop;
  logic [15:0]       fifo_head;
  logic              fifo_full, fifo_empty;
  logic              rd_done, rd_accept;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_word_val),
    .push_data (wr_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_word_d     = rd_word_q;
    rd_word_val_d = 1'b0;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    frame_done_d  = 1'b0;
    fifo_pop      = 1'b0;
    rd_done       = 1'b0;

    case (state_q)
      IDLE: begin
        // Reads win so the transmitter never starves behind a burst of writes.
        if (rd_pend_q != 2'd0) begin
          state_d    = READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = BASE + ADDR_W'(rd_ptr_q);
        end else if (!fifo_empty) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE + ADDR_W'(wr_ptr_q);
          mem_wdata_d = fifo_head;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          fifo_pop     = 1'b1;
          wr_cnt_d     = wr_cnt_q + ADDR_W'(1);
          wr_ptr_d     = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
          frame_done_d = (wr_ptr_q == PTR_LAST);
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      READ: begin
        if (mem_ack) begin
          rd_word_d     = mem_rdata;
          rd_word_val_d = 1'b1;
          rd_cnt_d      = rd_cnt_q + ADDR_W'(1);
          rd_done       = 1'b1;
          rd_ptr_d      = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
          mem_req_d     = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    rd_accept = rd_req && (rd_pend_q != 2'd3);
    rd_pend_d = rd_pend_q;
    if (rd_accept && !rd_done)      rd_pend_d = rd_pend_q + 2'd1;
    else if (!rd_accept && rd_done) rd_pend_d = rd_pend_q - 2'd1;

    err_d = err_q;
    if (wr_word_val && fifo_full)         err_d[ERR_WOVF] = 1'b1;
    if (rd_req && (rd_pend_q == 2'd3))    err_d[ERR_ROVR] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rd_pend_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_word_q     <= '0;
      rd_word_val_q <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_pend_q     <= rd_pend_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_word_q     <= rd_word_d;
      rd_word_val_q <= rd_word_val_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rd_word     = rd_word_q;
  assign rd_word_val = rd_word_val_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_word_sdram_port.sv
// Directed bench for word_sdram_port with a small frame (4 words) so pointer wrap is reachable.
module tb_word_sdram_port;

  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_word_val = 1'b0;
  logic [15:0]       wr_word = '0;
  logic              rd_req = 1'b0;
  logic [15:0]       rd_word;
  logic              rd_word_val;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_rdata = '0;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              frame_done;
  logic [1:0]        err;

  word_sdram_port #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (0),
    .FRAME_WORDS (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_word_val (wr_word_val),
    .wr_word     (wr_word),
    .rd_req      (rd_req),
    .rd_word     (rd_word),
    .rd_word_val (rd_word_val),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wr_cnt      (wr_cnt),
    .rd_cnt      (rd_cnt),
    .frame_done  (frame_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int                cyc;
  } tx_t;

  tx_t         tx_q[$];
  logic [15:0] rdword_q[$];
  logic [15:0] rdata_q[$];
  int          fd_q[$];

  int errors = 0;
  int checks = 0;
  int proto_err = 0;
  int cyc = 0;

  bit ack_en = 1'b1;
  int ack_delay = 1;
  int wait_cnt = 0;
  bit prev_req = 1'b0;
  bit acked_prev = 1'b0;
  logic [ADDR_W-1:0] cap_addr = '0;
  logic              cap_we = 1'b0;
  logic [15:0]       cap_wdata = '0;

  always @(posedge clk) cyc++;

  // SDRAM model: acks after ack_delay cycles, logs each transaction, watches protocol rules.
  always @(negedge clk) begin
    if (!rst) begin
      mem_ack    = 1'b0;
      wait_cnt   = 0;
      prev_req   = 1'b0;
      acked_prev = 1'b0;
    end else begin
      if (mem_req && acked_prev) proto_err++;
      if (mem_req && prev_req && !acked_prev) begin
        if (mem_addr !== cap_addr || mem_we !== cap_we || (mem_we && mem_wdata !== cap_wdata))
          proto_err++;
      end
      if (mem_req && !prev_req) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end
      acked_prev = 1'b0;
      mem_ack    = 1'b0;
      if (mem_req && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack    = 1'b1;
          wait_cnt   = 0;
          acked_prev = 1'b1;
          if (!mem_we) begin
            if (rdata_q.size() > 0) mem_rdata = rdata_q.pop_front();
            else                    mem_rdata = 16'hDEAD;
            tx_q.push_back('{1'b0, mem_addr, mem_rdata, cyc});
          end else begin
            tx_q.push_back('{1'b1, mem_addr, mem_wdata, cyc});
          end
        end else begin
          wait_cnt++;
        end
      end else if (!mem_req) begin
        wait_cnt = 0;
      end
      if (rd_word_val) rdword_q.push_back(rd_word);
      if (frame_done)  fd_q.push_back(cyc);
      prev_req = mem_req;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    wr_word_val = 1'b0;
    rd_req = 1'b0;
    ack_en = 1'b1;
    ack_delay = 1;
    repeat (3) @(negedge clk);
    tx_q.delete();
    rdword_q.delete();
    rdata_q.delete();
    fd_q.delete();
    proto_err = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] w);
    wr_word_val = 1'b1;
    wr_word = w;
    @(negedge clk);
    wr_word_val = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && rdword_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, rd_word_val, frame_done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, rd_word_val, frame_done});
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if ({mem_wdata, rd_word} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0", {mem_wdata, rd_word});
    end
    checks++;
    if (wr_cnt !== '0 || rd_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt);
    end
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b expected 00", err);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_req: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_writes();
    logic [15:0] exp_d [2];
    exp_d[0] = 16'h1234;
    exp_d[1] = 16'hABCD;
    do_reset();
    push_word(16'h1234);
    push_word(16'hABCD);
    wait_tx(2, 60);
    checks++;
    if (tx_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL wr_count_tx: got %0d expected 2", tx_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= tx_q.size()) begin
        errors++;
        $display("[TB] FAIL wr_tx%0d: got missing expected we=1 addr=%0d data=%h", i, i, exp_d[i]);
      end else if ({tx_q[i].we, tx_q[i].addr, tx_q[i].data} !== {1'b1, ADDR_W'(i), exp_d[i]}) begin
        errors++;
        $display("[TB] FAIL wr_tx%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 i, tx_q[i].we, tx_q[i].addr, tx_q[i].data, i, exp_d[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt !== ADDR_W'(2)) begin
      errors++;
      $display("[TB] FAIL wr_cnt: got %0d expected 2", wr_cnt);
    end
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_err: got %b expected 00", err);
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("[TB] FAIL wr_protocol: got %0d violations expected 0", proto_err);
    end
  endtask

  task automatic test_reads();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0001;
    exp_d[1] = 16'h0002;
    exp_d[2] = 16'h0000;
    do_reset();
    rdata_q.push_back(16'h0001);
    rdata_q.push_back(16'h0002);
    rdata_q.push_back(16'h0000);
    pulse_rd();
    pulse_rd();
    pulse_rd();
    wait_rd(3, 100);
    repeat (5) @(negedge clk);
    checks++;
    if (rdword_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL rd_val_pulses: got %0d expected 3", rdword_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= tx_q.size() || i >= rdword_q.size()) begin
        errors++;
        $display("[TB] FAIL rd_tx%0d: got missing expected addr=%0d word=%h", i, i, exp_d[i]);
      end else if ({tx_q[i].we, tx_q[i].addr, rdword_q[i]} !== {1'b0, ADDR_W'(i), exp_d[i]}) begin
        errors++;
        $display("[TB] FAIL rd_tx%0d: got we=%b addr=%0d word=%h expected we=0 addr=%0d word=%h",
                 i, tx_q[i].we, tx_q[i].addr, rdword_q[i], i, exp_d[i]);
      end
    end
    checks++;
    if (rd_cnt !== ADDR_W'(3) || wr_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL rd_cnt: got rd=%0d wr=%0d expected 3 0", rd_cnt, wr_cnt);
    end
    checks++;
    if (err !== 2'b00 || proto_err != 0) begin
      errors++;
      $display("[TB] FAIL rd_err: got err=%b proto=%0d expected 00 0", err, proto_err);
    end
  endtask

  task automatic test_priority();
    do_reset();
    rdata_q.push_back(16'h7777);
    rd_req = 1'b1;
    wr_word_val = 1'b1;
    wr_word = 16'h5A5A;
    @(negedge clk);
    rd_req = 1'b0;
    wr_word_val = 1'b0;
    wait_tx(2, 60);
    repeat (2) @(negedge clk);
    checks++;
    if (tx_q.size() < 1 || {tx_q[0].we, tx_q[0].addr, tx_q[0].data} !== {1'b0, ADDR_W'(0), 16'h7777}) begin
      errors++;
      $display("[TB] FAIL prio_first: got n=%0d expected read addr=0 data=7777", tx_q.size());
    end
    checks++;
    if (tx_q.size() < 2 || {tx_q[1].we, tx_q[1].addr, tx_q[1].data} !== {1'b1, ADDR_W'(0), 16'h5A5A}) begin
      errors++;
      $display("[TB] FAIL prio_second: got n=%0d expected write addr=0 data=5a5a", tx_q.size());
    end
    checks++;
    if (rd_word !== 16'h7777) begin
      errors++;
      $display("[TB] FAIL prio_rd_word: got %h expected 7777", rd_word);
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("[TB] FAIL prio_stable: got %0d violations expected 0", proto_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) push_word(16'h1000 + 16'(i));
    @(negedge clk);
    checks++;
    if (err !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ovf_err: got %b expected 01", err);
    end
    ack_en = 1'b1;
    wait_tx(8, 200);
    repeat (20) @(negedge clk);
    checks++;
    if (tx_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL ovf_writes: got %0d expected 8", tx_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= tx_q.size()) begin
        errors++;
        $display("[TB] FAIL ovf_tx%0d: got missing expected data=%h", i, 16'h1000 + 16'(i));
      end else if ({tx_q[i].we, tx_q[i].addr, tx_q[i].data} !== {1'b1, ADDR_W'(i % 4), 16'h1000 + 16'(i)}) begin
        errors++;
        $display("[TB] FAIL ovf_tx%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 i, tx_q[i].we, tx_q[i].addr, tx_q[i].data, i % 4, 16'h1000 + 16'(i));
      end
    end
    checks++;
    if (wr_cnt !== ADDR_W'(8) || err !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ovf_final: got wr_cnt=%0d err=%b expected 8 01", wr_cnt, err);
    end
  endtask

  task automatic test_frame_wrap();
    int exp_a [5];
    exp_a = '{0, 1, 2, 3, 0};
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < 5; i++) push_word(16'h2000 + 16'(i));
    wait_tx(5, 100);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= tx_q.size()) begin
        errors++;
        $display("[TB] FAIL wrap_addr%0d: got missing expected %0d", i, exp_a[i]);
      end else if (tx_q[i].addr !== ADDR_W'(exp_a[i])) begin
        errors++;
        $display("[TB] FAIL wrap_addr%0d: got %0d expected %0d", i, tx_q[i].addr, exp_a[i]);
      end
    end
    checks++;
    if (fd_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL wrap_fd_count: got %0d expected 1", fd_q.size());
    end
    checks++;
    if (fd_q.size() < 1 || tx_q.size() < 4) begin
      errors++;
      $display("[TB] FAIL wrap_fd_time: got missing expected pulse after 4th ack");
    end else if (fd_q[0] != tx_q[3].cyc + 1) begin
      errors++;
      $display("[TB] FAIL wrap_fd_time: got cycle %0d expected %0d", fd_q[0], tx_q[3].cyc + 1);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    ack_en = 1'b0;
    pulse_rd();
    push_word(16'hBEEF);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    checks++;
    if ({mem_req, mem_we} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_read_issued: got req/we=%b expected 10", {mem_req, mem_we});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_req_drop: got %b expected 0", mem_req);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (rdword_q.size() != 0 || tx_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_no_activity: got pulses=%0d tx=%0d expected 0 0", rdword_q.size(), tx_q.size());
    end
    checks++;
    if (wr_cnt !== '0 || rd_cnt !== '0 || err !== 2'b00 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_state: got wr=%0d rd=%0d err=%b req=%b expected 0 0 00 0",
               wr_cnt, rd_cnt, err, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_reads();
    test_priority();
    test_overflow();
    test_frame_wrap();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
